fp_class_arb: RTL and testbench

Round-robin arbiter and one-stage pipelined classifier for IEEE-style floating-point operands. It shares a single classification datapath between `N_REQ` requesters. Each cycle it grants at most one requester and classifies the granted operand as zero, subnormal, normal, infinity or NaN, using the zero-mantissa and exponent checks. It returns the class, sign and requester ID through a valid/ready output register. It sits between the operand-producing front ends and the special-case handling logic of the FP units.

---
 rtl/fp_class_arb.sv | 141 ++++++++++++++
 tb/tb_fp_class_arb.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_class_arb.sv
// Round-robin arbiter feeding a shared one-stage FP operand classifier.
// Optional FP_CLASS_ARB_SNAN_EN adds the registered res_snan flag.
module fp_class_arb #(
  parameter int SIGN_W = 1,
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23,
  parameter int N_REQ  = 4,
  localparam int FP_W  = SIGN_W + EXPO_W + MANT_W,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*FP_W-1:0] req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ID_W-1:0]       res_id,
  output logic                  res_sign,
`ifdef FP_CLASS_ARB_SNAN_EN
  output logic                  res_snan,
`endif
  output logic [4:0]            res_class
);

  logic [ID_W-1:0]   r_ptr;
  logic              r_valid;
  logic [ID_W-1:0]   r_id;
  logic              r_sign;
  logic [4:0]        r_class;

  logic              w_accept;
  logic              w_any;
  logic [ID_W-1:0]   w_gidx;
  logic [N_REQ-1:0]  w_grant;
  logic [ID_W-1:0]   w_ptr_nxt;
  logic [FP_W-1:0]   w_op;
  logic [EXPO_W-1:0] w_expo;
  logic [MANT_W-1:0] w_mant;
  logic              w_sign;
  logic              w_ez;
  logic              w_eo;
  logic              w_mz;
  logic [4:0]        w_class;

  function automatic logic [ID_W-1:0] wrap_idx(
    input logic [ID_W-1:0] p,
    input int              i
  );
    int k;
    k = int'(p) + i;
    if (k >= N_REQ) k = k - N_REQ;
    return ID_W'(k);
  endfunction

  assign w_accept = !r_valid | res_ready;

  // First valid requester at or after r_ptr, wrapping
  always_comb begin
    w_any  = 1'b0;
    w_gidx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_any && w_accept &&
          req_valid[wrap_idx(r_ptr, i)]) begin
        w_any  = 1'b1;
        w_gidx = wrap_idx(r_ptr, i);
      end
    end
  end

  always_comb begin
    w_grant         = '0;
    w_grant[w_gidx] = w_any;
  end

  assign req_ready = w_grant;

  assign w_ptr_nxt = (w_gidx == ID_W'(N_REQ - 1))
                   ? '0 : w_gidx + 1'b1;

  assign w_op   = req_data[w_gidx*FP_W +: FP_W];
  assign w_sign = w_op[FP_W-1];
  assign w_expo = w_op[MANT_W +: EXPO_W];
  assign w_mant = w_op[MANT_W-1:0];
  assign w_ez   = (w_expo == '0);
  assign w_eo   = (w_expo == '1);
  assign w_mz   = (w_mant == '0);

  always_comb begin
    w_class = 5'b00100;
    unique case (1'b1)
      w_ez &  w_mz: w_class = 5'b00001;
      w_ez & !w_mz: w_class = 5'b00010;
      w_eo &  w_mz: w_class = 5'b01000;
      w_eo & !w_mz: w_class = 5'b10000;
      default:      w_class = 5'b00100;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_sign  <= 1'b0;
      r_class <= '0;
    end else if (w_any) begin
      r_ptr   <= w_ptr_nxt;
      r_valid <= 1'b1;
      r_id    <= w_gidx;
      r_sign  <= w_sign;
      r_class <= w_class;
    end else if (res_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef FP_CLASS_ARB_SNAN_EN
  logic r_snan;
  logic w_snan;

  // Signaling NaN: quiet bit (mantissa MSB) clear
  assign w_snan = w_eo & !w_mz & !w_mant[MANT_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snan <= 1'b0;
    end else if (w_any) begin
      r_snan <= w_snan;
    end
  end

  assign res_snan = r_snan;
`endif

  assign res_valid = r_valid;
  assign res_id    = r_id;
  assign res_sign  = r_sign;
  assign res_class = r_class;

endmodule

// File: tb/tb_fp_class_arb.sv
// Scoreboard bench for fp_class_arb, FP32 with four requesters.
// Reference model tracks pointer, slot occupancy and expected results.
module tb_fp_class_arb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         res_valid;
  logic         res_ready;
  logic [1:0]   res_id;
  logic         res_sign;
  logic [4:0]   res_class;
  logic         res_snan_w;

  always #5 clk = ~clk;

  fp_class_arb #(
    .SIGN_W(1), .EXPO_W(8), .MANT_W(23), .N_REQ(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_sign  (res_sign),
`ifdef FP_CLASS_ARB_SNAN_EN
    .res_snan  (res_snan_w),
`endif
    .res_class (res_class)
  );

`ifndef FP_CLASS_ARB_SNAN_EN
  assign res_snan_w = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] id;
    logic       sign;
    logic [4:0] cls;
    logic       snan;
  } res_t;

  int   n_vec = 0;
  int   n_err = 0;
  res_t q[$];
  res_t m_last;
  logic m_valid;
  logic [1:0] m_ptr;

  logic [31:0] vals [7] = '{
    32'h00000000, 32'h80000001, 32'h3F800000,
    32'h7F800000, 32'h7FC00000, 32'hFF800000,
    32'h7FA00000
  };

  wire [9:0] w_obs = {res_valid, res_id, res_sign,
                      res_class, res_snan_w};

  function automatic logic [4:0] cls_of(logic [31:0] x);
    if (x[30:23] == 8'h00)
      return (x[22:0] == 0) ? 5'h01 : 5'h02;
    if (x[30:23] == 8'hFF)
      return (x[22:0] == 0) ? 5'h08 : 5'h10;
    return 5'h04;
  endfunction

  function automatic logic snan_of(logic [31:0] x);
`ifdef FP_CLASS_ARB_SNAN_EN
    return cls_of(x) == 5'h10 && !x[22];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] exp_grant();
    logic [3:0] g;
    int k;
    g = 4'b0;
    if (m_valid && !res_ready) return g;
    for (int i = 0; i < 4; i++) begin
      k = (int'(m_ptr) + i) % 4;
      if (req_valid[k] && g == 0) g[k] = 1'b1;
    end
    return g;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_ptr   = 2'd0;
    m_last  = '0;
    q.delete();
  endtask

  task automatic tick();
    logic [3:0]  g;
    logic [31:0] op;
    int          gi;
    res_t        e;
    g  = exp_grant();
    gi = -1;
    for (int i = 0; i < 4; i++) if (g[i]) gi = i;
    if (gi >= 0) begin
      op     = req_data[gi*32 +: 32];
      e.id   = 2'(gi);
      e.sign = op[31];
      e.cls  = cls_of(op);
      e.snan = snan_of(op);
      q.push_back(e);
    end
    @(posedge clk);
    if (gi >= 0) begin
      m_valid = 1'b1;
      m_ptr   = (gi == 3) ? 2'd0 : 2'(gi + 1);
    end else if (res_ready) begin
      m_valid = 1'b0;
    end
    #1;
    if (gi >= 0 && q.size() > 0) m_last = q.pop_front();
  endtask

  task automatic do_reset();
    req_valid = '0;
    res_ready = 1'b1;
    rst_n     = 1'b0;
    #2;
    model_reset();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    res_ready = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if (w_obs !== 10'b0) begin
      n_err++;
      $display("FAIL reset_out got %h want 000", w_obs);
    end
    n_vec++;
    if (req_ready !== 4'b0) begin
      n_err++;
      $display("FAIL reset_rdy got %b want 0000", req_ready);
    end
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_classes();
    logic [31:0] cv [5] = '{
      32'h00000000, 32'h80000001, 32'h3F800000,
      32'h7F800000, 32'h7FC00000
    };
    logic [4:0] cx [5] = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10};
    logic       sx [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_valid = 4'b0001;
      req_data  = {96'b0, cv[i]};
      #1;
      n_vec++;
      if (req_ready !== exp_grant()) begin
        n_err++;
        $display("FAIL cls_rdy[%0d] got %b want %b",
                 i, req_ready, exp_grant());
      end
      tick();
      n_vec++;
      if (w_obs !== {m_valid, m_last} ||
          res_class !== cx[i] || res_sign !== sx[i]) begin
        n_err++;
        $display("FAIL cls_out[%0d] got %h want %h cls %h",
                 i, w_obs, {m_valid, m_last}, cx[i]);
      end
    end
    req_valid = '0;
    tick();
    n_vec++;
    if (w_obs !== {m_valid, m_last} || res_valid !== 1'b0) begin
      n_err++;
      $display("FAIL cls_drain got %h want %h",
               w_obs, {m_valid, m_last});
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 4; r++)
        req_data[r*32 +: 32] = vals[$urandom_range(0, 6)];
      #1;
      n_vec++;
      if (req_ready !== 4'(1 << (c % 4))) begin
        n_err++;
        $display("FAIL rr_rdy[%0d] got %b want %b",
                 c, req_ready, 4'(1 << (c % 4)));
      end
      tick();
      n_vec++;
      if (w_obs !== {m_valid, m_last} ||
          res_id !== 2'(c % 4)) begin
        n_err++;
        $display("FAIL rr_out[%0d] got %h want %h",
                 c, w_obs, {m_valid, m_last});
      end
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] held;
    do_reset();
    req_valid = 4'b1111;
    for (int r = 0; r < 4; r++)
      req_data[r*32 +: 32] = vals[r + 1];
    for (int c = 0; c < 3; c++) tick();
    held = w_obs;
    n_vec++;
    if (w_obs !== {m_valid, m_last} || res_id !== 2'd2) begin
      n_err++;
      $display("FAIL bp_pend got %h want %h",
               w_obs, {m_valid, m_last});
    end
    res_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++;
      if (req_ready !== exp_grant() || req_ready !== 4'b0) begin
        n_err++;
        $display("FAIL bp_rdy[%0d] got %b want 0000", c, req_ready);
      end
      tick();
      n_vec++;
      if (w_obs !== {m_valid, m_last} || w_obs !== held) begin
        n_err++;
        $display("FAIL bp_hold[%0d] got %h want %h",
                 c, w_obs, held);
      end
    end
    res_ready = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 4'b1000) begin
      n_err++;
      $display("FAIL bp_rel_rdy got %b want 1000", req_ready);
    end
    tick();
    n_vec++;
    if (w_obs !== {m_valid, m_last} || res_id !== 2'd3) begin
      n_err++;
      $display("FAIL bp_rel_out got %h want %h",
               w_obs, {m_valid, m_last});
    end
  endtask

  task automatic test_sparse();
    logic [1:0] order [4] = '{2'd3, 2'd1, 2'd3, 2'd1};
    do_reset();
    req_data  = {vals[5], vals[2], vals[1], vals[0]};
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_vec++;
      if (req_ready !== exp_grant() ||
          req_ready !== 4'(1 << order[c])) begin
        n_err++;
        $display("FAIL sp_rdy[%0d] got %b want %b",
                 c, req_ready, 4'(1 << order[c]));
      end
      tick();
      n_vec++;
      if (w_obs !== {m_valid, m_last}) begin
        n_err++;
        $display("FAIL sp_out[%0d] got %h want %h",
                 c, w_obs, {m_valid, m_last});
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b1111;
    req_data  = {vals[3], vals[2], vals[1], vals[4]};
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (res_valid !== 1'b0 || res_class !== 5'b0 ||
        w_obs !== 10'b0) begin
      n_err++;
      $display("FAIL rm_clear got %h want 000", w_obs);
    end
    model_reset();
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL rm_first got %b want 0001", req_ready);
    end
    tick();
    n_vec++;
    if (w_obs !== {m_valid, m_last} || res_id !== 2'd0) begin
      n_err++;
      $display("FAIL rm_out got %h want %h",
               w_obs, {m_valid, m_last});
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 60; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      res_ready = ($urandom_range(0, 3) != 0);
      for (int r = 0; r < 4; r++)
        req_data[r*32 +: 32] = vals[$urandom_range(0, 6)];
      #1;
      n_vec++;
      if (req_ready !== exp_grant()) begin
        n_err++;
        $display("FAIL rnd_rdy[%0d] got %b want %b",
                 c, req_ready, exp_grant());
      end
      tick();
      n_vec++;
      if (w_obs !== {m_valid, m_last}) begin
        n_err++;
        $display("FAIL rnd_out[%0d] got %h want %h",
                 c, w_obs, {m_valid, m_last});
      end
    end
  endtask

`ifdef FP_CLASS_ARB_SNAN_EN
  task automatic test_snan();
    logic [31:0] sv [2] = '{32'h7FA00000, 32'h7FC00000};
    logic        sx [2] = '{1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      req_valid = 4'b0001;
      req_data  = {96'b0, sv[i]};
      tick();
      n_vec++;
      if (w_obs !== {m_valid, m_last} ||
          res_class !== 5'h10 || res_snan_w !== sx[i]) begin
        n_err++;
        $display("FAIL snan[%0d] got %h snan %b want %b",
                 i, w_obs, res_snan_w, sx[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_classes();
    test_round_robin();
    test_backpressure();
    test_sparse();
    test_reset_mid();
`ifdef FP_CLASS_ARB_SNAN_EN
    test_snan();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
